chimera_cluster_ctrl: RTL and testbench
=======================================

CHIMERA_CLUSTER_CTRL -- requirements
Module: chimera_cluster_ctrl

Interface
REQ-001 SHALL have parameter NumClusters, default 5, number of controlled clusters (1..16).
REQ-002 SHALL have parameter RstHoldCycles, default 8, cycles cluster reset is held with clock running (>=1).
REQ-003 SHALL have parameter IsoSettleCycles, default 4, cycles isolation settles around reset release/assert (>=1).
REQ-004 SHALL have parameter BootAddrDefault, default 32'h3000_0000, reset value of every boot address.
REQ-005 SHALL have clk_i  input  1  the single clock.
REQ-006 SHALL have rst_i  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have APB slave inputs paddr_i 32, psel_i 1, penable_i 1, pwrite_i 1, pwdata_i 32, pstrb_i 4.
REQ-008 SHALL have APB slave outputs prdata_o 32, pready_o 1, pslverr_o 1.
REQ-009 SHALL have cluster_clk_en_o  output  NumClusters  per-cluster clock-gate enable.
REQ-010 SHALL have cluster_rst_o  output  NumClusters  per-cluster reset, active-high.
REQ-011 SHALL have cluster_iso_o  output  NumClusters  per-cluster AXI/IRQ isolation, active-high.
REQ-012 SHALL have cluster_boot_addr_o  output  NumClusters x 32  per-cluster boot address.

Function
REQ-013 Register map (paddr_i[7:0], word aligned): CTRL[i] at 0x00+4i, BOOT_ADDR[i] at 0x40+4i, STATUS at 0x80.
REQ-014 CTRL[i]: bit0 enable (RW), bit1 soft-reset request (write-1 sets pending flag, reads 0); other bits read 0.
REQ-015 STATUS (RO): bit i = cluster i ACTIVE; bit 16+i = cluster i not OFF; unused bits 0.
REQ-016 APB: pready_o=1 whenever psel_i&penable_i (zero wait states); writes commit on that access-phase edge.
REQ-017 pstrb_i SHALL byte-mask writes to BOOT_ADDR; CTRL written only when pstrb_i[0]=1.
REQ-018 pslverr_o=1 for unmapped offset, cluster index >= NumClusters, write to STATUS, or BOOT_ADDR write while cluster not OFF; erroring writes SHALL not modify state.
REQ-019 prdata_o=0 on error and outside access phase; pslverr_o=0 outside access phase.
REQ-020 Per-cluster FSM states/outputs (clk_en,rst,iso): OFF(0,1,1), HOLD(1,1,1), RELEASE(1,0,1), ACTIVE(1,0,0), ISOLATE(1,0,1); outputs registered from state.
REQ-021 OFF -> HOLD when enable=1; HOLD lasts exactly RstHoldCycles cycles.
REQ-022 At HOLD end: enable=1 -> RELEASE, enable=0 -> OFF.
REQ-023 RELEASE lasts exactly IsoSettleCycles cycles, then -> ACTIVE unconditionally.
REQ-024 ACTIVE -> ISOLATE when enable=0 or soft-reset pending; pending flag cleared on that transition.
REQ-025 ISOLATE lasts exactly IsoSettleCycles cycles, then -> HOLD.
REQ-026 Soft-reset request while OFF SHALL be discarded; in HOLD/RELEASE/ISOLATE it stays pending until ACTIVE.
REQ-027 Enable cleared during HOLD/RELEASE/ISOLATE SHALL not abort the sequence; it takes effect at the next decision point.
REQ-028 Per-cluster down-counter loaded with duration-1 on state entry; transition when counter=0; width $clog2(max(RstHoldCycles,IsoSettleCycles)).
REQ-029 First output change SHALL occur one cycle after the committing APB access phase.
REQ-030 Clusters SHALL sequence independently; simultaneous events on different clusters SHALL not interact.
REQ-031 cluster_boot_addr_o[i] SHALL reflect BOOT_ADDR[i] register directly.

Reset
REQ-032 On rst_i=1, all FSMs OFF, enables and pending flags 0, counters 0, BOOT_ADDR=BootAddrDefault, asynchronously.
REQ-033 Reset outputs: cluster_clk_en_o=0, cluster_rst_o all-1, cluster_iso_o all-1, prdata_o=0, pslverr_o=0, pready_o=0.
REQ-034 rst_i asserted mid-sequence SHALL force OFF outputs immediately, without completing isolation.

Verification (defaults)
REQ-035 Release reset -> clk_en=5'b00000, rst=5'b11111, iso=5'b11111, all boot_addr 0x3000_0000, STATUS reads 0.
REQ-036 Write 0x08=0x1 -> clk_en[2]=1 next cycle; rst[2]=1 for 8 cycles; iso[2]=1 4 more cycles; then iso[2]=0; STATUS=0x0004_0004.
REQ-037 Cluster 2 ACTIVE, write 0x08=0x3 -> iso 4 cycles, rst 8 cycles, release 4 cycles, ACTIVE; clk_en[2] stays 1 throughout.
REQ-038 Write 0x48=0x1000_0000 while cluster 2 ACTIVE -> pslverr=1, readback 0x3000_0000; after disable to OFF, same write -> pslverr=0, readback 0x1000_0000.
REQ-039 Access 0x14 (cluster 5) or 0x84 -> pslverr=1, prdata=0, no output change.
REQ-040 rst_i pulsed while cluster 2 in HOLD -> same cycle clk_en[2]=0, rst[2]=1, iso[2]=1; CTRL[2] reads 0.

Source files
------------

// File: rtl/chimera_cluster_ctrl.sv
// Chimera cluster controller: APB register file plus one power-sequencing FSM per
// cluster that drives clock-gate enable, reset and AXI/IRQ isolation.
module chimera_cluster_ctrl #(
  parameter int          NumClusters     = 5,
  parameter int          RstHoldCycles   = 8,
  parameter int          IsoSettleCycles = 4,
  parameter logic [31:0] BootAddrDefault = 32'h3000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [31:0]                  paddr_i,
  input  logic                         psel_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [31:0]                  pwdata_i,
  input  logic [3:0]                   pstrb_i,
  output logic [31:0]                  prdata_o,
  output logic                         pready_o,
  output logic                         pslverr_o,
  output logic [NumClusters-1:0]       cluster_clk_en_o,
  output logic [NumClusters-1:0]       cluster_rst_o,
  output logic [NumClusters-1:0]       cluster_iso_o,
  output logic [NumClusters-1:0][31:0] cluster_boot_addr_o
);

  localparam int MaxDur = (RstHoldCycles > IsoSettleCycles) ? RstHoldCycles : IsoSettleCycles;
  localparam int CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] IsoLoad  = CntW'(IsoSettleCycles - 1);

  typedef enum logic [2:0] {
    StOff,
    StHold,
    StRelease,
    StActive,
    StIsolate
  } clState_e;

  clState_e                      state_q [NumClusters];
  clState_e                      state_d [NumClusters];
  logic [CntW-1:0]               cnt_q   [NumClusters];
  logic [CntW-1:0]               cnt_d   [NumClusters];
  logic [NumClusters-1:0]        enable_q, enable_d;
  logic [NumClusters-1:0]        pending_q, pending_d;
  logic [NumClusters-1:0][31:0]  bootAddr_q, bootAddr_d;
  logic [NumClusters-1:0]        clkEn_q, clRst_q, iso_q;

  logic                          apbAccess;
  logic [7:0]                    offset;
  logic [3:0]                    idx;
  logic                          isCtrl, isBoot, isStatus, idxOk;
  logic                          apbErr;
  logic [31:0]                   readData;
  logic [31:0]                   statusWord;
  logic                          selIsOff, selEnable;
  logic [31:0]                   selBoot;
  logic                          wrOk;
  logic [NumClusters-1:0]        ctrlWe, bootWe;
  logic                          unused_paddr;

  assign apbAccess    = psel_i & penable_i;
  assign offset       = paddr_i[7:0];
  assign idx          = offset[5:2];
  assign isCtrl       = (offset[7:6] == 2'b00) && (offset[1:0] == 2'b00);
  assign isBoot       = (offset[7:6] == 2'b01) && (offset[1:0] == 2'b00);
  assign isStatus     = (offset == 8'h80);
  assign idxOk        = int'(idx) < NumClusters;
  assign unused_paddr = ^paddr_i[31:8];

  // Register decode and read mux; the selected cluster is picked by a loop so an
  // out-of-range index never reaches an array select.
  always_comb begin
    selIsOff  = 1'b0;
    selEnable = 1'b0;
    selBoot   = '0;
    statusWord = '0;
    for (int i = 0; i < NumClusters; i++) begin
      if (idx == 4'(i)) begin
        selIsOff  = (state_q[i] == StOff);
        selEnable = enable_q[i];
        selBoot   = bootAddr_q[i];
      end
      statusWord[i]      = (state_q[i] == StActive);
      statusWord[16 + i] = (state_q[i] != StOff);
    end

    apbErr   = 1'b0;
    readData = '0;
    if (isCtrl) begin
      apbErr   = !idxOk;
      readData = {31'd0, selEnable};
    end else if (isBoot) begin
      apbErr   = !idxOk || (pwrite_i && !selIsOff);
      readData = selBoot;
    end else if (isStatus) begin
      apbErr   = pwrite_i;
      readData = statusWord;
    end else begin
      apbErr   = 1'b1;
    end
  end

  assign pready_o  = apbAccess & ~rst_i;
  assign pslverr_o = apbAccess & apbErr & ~rst_i;
  assign prdata_o  = (apbAccess && !pwrite_i && !apbErr && !rst_i) ? readData : 32'd0;

  assign wrOk = apbAccess & pwrite_i & ~apbErr;

  always_comb begin
    ctrlWe = '0;
    bootWe = '0;
    for (int i = 0; i < NumClusters; i++) begin
      ctrlWe[i] = wrOk && isCtrl && pstrb_i[0] && (idx == 4'(i));
      bootWe[i] = wrOk && isBoot && (idx == 4'(i));
    end
  end

  // Sequencing decisions use the enable/pending values from before any write on the
  // same edge, so a new command is acted on one cycle after it commits. A soft-reset
  // request landing on the same edge as an ACTIVE->ISOLATE decision stays pending.
  always_comb begin
    for (int i = 0; i < NumClusters; i++) begin
      state_d[i]    = state_q[i];
      cnt_d[i]      = cnt_q[i];
      enable_d[i]   = enable_q[i];
      pending_d[i]  = pending_q[i];
      bootAddr_d[i] = bootAddr_q[i];

      case (state_q[i])
        StOff: begin
          if (enable_q[i]) begin
            state_d[i] = StHold;
            cnt_d[i]   = HoldLoad;
          end
        end
        StHold: begin
          if (cnt_q[i] == '0) begin
            if (enable_q[i]) begin
              state_d[i] = StRelease;
              cnt_d[i]   = IsoLoad;
            end else begin
              state_d[i] = StOff;
            end
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = StActive;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        StActive: begin
          if (!enable_q[i] || pending_q[i]) begin
            state_d[i]   = StIsolate;
            cnt_d[i]     = IsoLoad;
            pending_d[i] = 1'b0;
          end
        end
        StIsolate: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = StHold;
            cnt_d[i]   = HoldLoad;
          end else begin
            cnt_d[i] = cnt_q[i] - 1'b1;
          end
        end
        default: begin
          state_d[i] = StOff;
          cnt_d[i]   = '0;
        end
      endcase

      if (ctrlWe[i]) begin
        enable_d[i] = pwdata_i[0];
        if (pwdata_i[1] && (state_q[i] != StOff)) begin
          pending_d[i] = 1'b1;
        end
      end

      if (bootWe[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (pstrb_i[b]) begin
            bootAddr_d[i][8*b +: 8] = pwdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable_q   <= '0;
      pending_q  <= '0;
      bootAddr_q <= {NumClusters{BootAddrDefault}};
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      bootAddr_q <= bootAddr_d;
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumClusters; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
        clkEn_q[i] <= 1'b0;
        clRst_q[i] <= 1'b1;
        iso_q[i]   <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NumClusters; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        clkEn_q[i] <= (state_d[i] != StOff);
        clRst_q[i] <= (state_d[i] == StOff) || (state_d[i] == StHold);
        iso_q[i]   <= (state_d[i] != StActive);
      end
    end
  end

  assign cluster_clk_en_o    = clkEn_q;
  assign cluster_rst_o       = clRst_q;
  assign cluster_iso_o       = iso_q;
  assign cluster_boot_addr_o = bootAddr_q;

endmodule

// File: tb/tb_chimera_cluster_ctrl.sv
// Self-checking bench for chimera_cluster_ctrl: directed sequences with literal
// expectations, then random APB traffic compared against a phase/time-left model.
module tb_chimera_cluster_ctrl;

   localparam int N = 5;
   localparam int H = 8;
   localparam int I = 4;
   localparam logic [31:0] BootDef = 32'h3000_0000;

   localparam int OFF = 0;
   localparam int HOLD = 1;
   localparam int REL = 2;
   localparam int ACT = 3;
   localparam int ISO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0] pstrb = '0;
   logic psel = 1'b0;
   logic penable = 1'b0;
   logic pwrite = 1'b0;
   logic [31:0] prdata;
   logic pready;
   logic pslverr;
   logic [N-1:0] clkEn;
   logic [N-1:0] clRst;
   logic [N-1:0] clIso;
   logic [N-1:0][31:0] bootAddr;

   int checks = 0;
   int failures = 0;

   // Behavioural model: phase of each cluster plus cycles left in that phase
   int mPhase [N];
   int mLeft [N];
   bit mEn [N];
   bit mPend [N];
   logic [31:0] mBoot [N];

   // Output table per phase, indexed OFF, HOLD, REL, ACT, ISO
   bit enTab [5] = '{0, 1, 1, 1, 1};
   bit rstTab [5] = '{1, 1, 0, 0, 0};
   bit isoTab [5] = '{1, 1, 1, 0, 1};

   chimera_cluster_ctrl #(
      .NumClusters(N),
      .RstHoldCycles(H),
      .IsoSettleCycles(I),
      .BootAddrDefault(BootDef)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .paddr_i(paddr),
      .psel_i(psel),
      .penable_i(penable),
      .pwrite_i(pwrite),
      .pwdata_i(pwdata),
      .pstrb_i(pstrb),
      .prdata_o(prdata),
      .pready_o(pready),
      .pslverr_o(pslverr),
      .cluster_clk_en_o(clkEn),
      .cluster_rst_o(clRst),
      .cluster_iso_o(clIso),
      .cluster_boot_addr_o(bootAddr)
   );

   always #5 clk = ~clk;

   // Compare one value and keep the running counts
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Register map rules: word aligned, CTRL/BOOT indexed below N, STATUS read-only,
   // BOOT writable only while its cluster is OFF
   function automatic bit modelErr(input logic [31:0] a, input bit wr);
      int o;
      o = int'(a[7:0]);
      if (o % 4 != 0) return 1'b1;
      if (o < 64) return (o / 4) >= N;
      if (o < 128) begin
         if ((o - 64) / 4 >= N) return 1'b1;
         return wr && (mPhase[(o - 64) / 4] != OFF);
      end
      if (o == 128) return wr;
      return 1'b1;
   endfunction

   function automatic logic [31:0] modelRdata(input logic [31:0] a);
      int o;
      logic [31:0] r;
      r = '0;
      if (modelErr(a, 1'b0)) return 32'd0;
      o = int'(a[7:0]);
      if (o < 64) return {31'd0, mEn[o / 4]};
      if (o < 128) return mBoot[(o - 64) / 4];
      for (int c = 0; c < N; c++) begin
         if (mPhase[c] == ACT) r[c] = 1'b1;
         if (mPhase[c] != OFF) r[16 + c] = 1'b1;
      end
      return r;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < N; c++) begin
         mPhase[c] = OFF;
         mLeft[c] = 0;
         mEn[c] = 1'b0;
         mPend[c] = 1'b0;
         mBoot[c] = BootDef;
      end
   endtask

   // One clock edge of the model: sequencing sees pre-write enable/pending,
   // then the committing write is applied
   task automatic modelStep();
      bit wOk;
      int o;
      int w;
      int oldPh [N];
      wOk = psel && penable && pwrite && !modelErr(paddr, 1'b1);
      for (int c = 0; c < N; c++) oldPh[c] = mPhase[c];
      for (int c = 0; c < N; c++) begin
         case (mPhase[c])
            OFF: if (mEn[c]) begin mPhase[c] = HOLD; mLeft[c] = H; end
            HOLD: begin
               mLeft[c]--;
               if (mLeft[c] == 0) begin
                  if (mEn[c]) begin mPhase[c] = REL; mLeft[c] = I; end
                  else mPhase[c] = OFF;
               end
            end
            REL: begin
               mLeft[c]--;
               if (mLeft[c] == 0) mPhase[c] = ACT;
            end
            ACT: if (!mEn[c] || mPend[c]) begin
               mPhase[c] = ISO;
               mLeft[c] = I;
               mPend[c] = 1'b0;
            end
            default: begin
               mLeft[c]--;
               if (mLeft[c] == 0) begin mPhase[c] = HOLD; mLeft[c] = H; end
            end
         endcase
      end
      if (wOk) begin
         o = int'(paddr[7:0]);
         if (o < 64) begin
            w = o / 4;
            if (pstrb[0]) begin
               mEn[w] = pwdata[0];
               if (pwdata[1] && oldPh[w] != OFF) mPend[w] = 1'b1;
            end
         end else if (o < 128) begin
            w = (o - 64) / 4;
            for (int b = 0; b < 4; b++)
               if (pstrb[b]) mBoot[w][8*b +: 8] = pwdata[8*b +: 8];
         end
      end
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) modelReset();
         else modelStep();
      end
   end

   // Per-cycle comparison of every output against the model, one time unit before
   // the next active edge
   initial begin
      logic [N-1:0] eEn, eRst, eIso;
      bit acc, eErr;
      forever begin
         @(negedge clk);
         #4;
         if (rst !== 1'b0) continue;
         for (int c = 0; c < N; c++) begin
            eEn[c] = enTab[mPhase[c]];
            eRst[c] = rstTab[mPhase[c]];
            eIso[c] = isoTab[mPhase[c]];
            checkOutput($sformatf("boot_addr[%0d]", c), bootAddr[c], mBoot[c]);
         end
         checkOutput("clk_en", 32'(clkEn), 32'(eEn));
         checkOutput("cluster_rst", 32'(clRst), 32'(eRst));
         checkOutput("cluster_iso", 32'(clIso), 32'(eIso));
         acc = psel && penable;
         eErr = acc && modelErr(paddr, pwrite);
         checkOutput("pready", 32'(pready), 32'(acc));
         checkOutput("pslverr", 32'(pslverr), 32'(eErr));
         checkOutput("prdata", prdata, (acc && !pwrite && !eErr) ? modelRdata(paddr) : 32'd0);
      end
   end

   // One APB transfer: setup phase, access phase (response sampled late in it), idle
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input bit wr,
                                output logic [31:0] rdata, output logic err);
      @(negedge clk);
      paddr = addr;
      pwdata = data;
      pstrb = strb;
      pwrite = wr;
      psel = 1'b1;
      penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #4;
      rdata = prdata;
      err = pslverr;
      @(negedge clk);
      psel = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      #500000;
      failures++;
      $display("[TB] FAIL watchdog: time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      logic er;
      logic [31:0] a, d;
      logic [3:0] s;
      int kind, cl, gap;
      bit wr;

      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkOutput("reset clk_en", 32'(clkEn), 32'h0);
      checkOutput("reset cluster_rst", 32'(clRst), 32'h1f);
      checkOutput("reset cluster_iso", 32'(clIso), 32'h1f);
      checkOutput("reset boot_addr[0]", bootAddr[0], 32'h3000_0000);
      checkOutput("reset boot_addr[4]", bootAddr[4], 32'h3000_0000);
      checkOutput("reset pready", 32'(pready), 32'h0);
      applyStimulus(32'h80, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("reset STATUS", rd, 32'h0);
      checkOutput("reset STATUS err", 32'(er), 32'h0);

      // Power-up of cluster 2
      applyStimulus(32'h08, 32'h1, 4'hf, 1'b1, rd, er);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         checkOutput($sformatf("up clk_en[2] k=%0d", k), 32'(clkEn[2]), 32'h1);
         checkOutput($sformatf("up rst[2] k=%0d", k), 32'(clRst[2]), 32'(k <= 8));
         checkOutput($sformatf("up iso[2] k=%0d", k), 32'(clIso[2]), 32'(k <= 12));
      end
      applyStimulus(32'h80, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("up STATUS", rd, 32'h0004_0004);

      // Soft reset of active cluster 2
      applyStimulus(32'h08, 32'h3, 4'hf, 1'b1, rd, er);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         checkOutput($sformatf("soft clk_en[2] k=%0d", k), 32'(clkEn[2]), 32'h1);
         checkOutput($sformatf("soft rst[2] k=%0d", k), 32'(clRst[2]), 32'(k >= 5 && k <= 12));
         checkOutput($sformatf("soft iso[2] k=%0d", k), 32'(clIso[2]), 32'(k <= 16));
      end

      // Boot address protected while not OFF
      applyStimulus(32'h48, 32'h1000_0000, 4'hf, 1'b1, rd, er);
      checkOutput("boot wr active err", 32'(er), 32'h1);
      applyStimulus(32'h48, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("boot rd after reject", rd, 32'h3000_0000);
      applyStimulus(32'h08, 32'h0, 4'hf, 1'b1, rd, er);
      repeat (14) @(negedge clk);
      checkOutput("disabled clk_en[2]", 32'(clkEn[2]), 32'h0);
      applyStimulus(32'h48, 32'h1000_0000, 4'hf, 1'b1, rd, er);
      checkOutput("boot wr off err", 32'(er), 32'h0);
      applyStimulus(32'h48, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("boot rd after write", rd, 32'h1000_0000);
      applyStimulus(32'h48, 32'hAABB_CCDD, 4'b0101, 1'b1, rd, er);
      checkOutput("boot byte-masked", bootAddr[2], 32'h10BB_00DD);

      // Out-of-range cluster and unmapped offset
      applyStimulus(32'h14, 32'h1, 4'hf, 1'b1, rd, er);
      checkOutput("cl5 wr err", 32'(er), 32'h1);
      applyStimulus(32'h14, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("cl5 rd err", 32'(er), 32'h1);
      checkOutput("cl5 rd data", rd, 32'h0);
      applyStimulus(32'h84, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("0x84 err", 32'(er), 32'h1);
      checkOutput("0x84 data", rd, 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("no change clk_en", 32'(clkEn), 32'h0);

      // Soft reset while OFF is dropped
      applyStimulus(32'h0C, 32'h2, 4'hf, 1'b1, rd, er);
      repeat (3) @(negedge clk);
      applyStimulus(32'h0C, 32'h1, 4'hf, 1'b1, rd, er);
      repeat (20) @(negedge clk);
      checkOutput("dropped soft iso[3]", 32'(clIso[3]), 32'h0);

      // Asynchronous reset during HOLD
      applyStimulus(32'h08, 32'h1, 4'hf, 1'b1, rd, er);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("async clk_en", 32'(clkEn), 32'h0);
      checkOutput("async rst", 32'(clRst), 32'h1f);
      checkOutput("async iso", 32'(clIso), 32'h1f);
      rst = 1'b0;
      applyStimulus(32'h08, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("async CTRL[2]", rd, 32'h0);
      applyStimulus(32'h48, 32'h0, 4'hf, 1'b0, rd, er);
      checkOutput("async BOOT[2]", rd, 32'h3000_0000);

      // Random traffic, checked every cycle by the compare process
      for (int t = 0; t < 300; t++) begin
         kind = int'($urandom_range(0, 9));
         cl = int'($urandom_range(0, N));
         wr = ($urandom_range(0, 2) != 0);
         d = $urandom;
         s = ($urandom_range(0, 3) != 0) ? 4'hf : 4'($urandom_range(0, 15));
         a = {24'($urandom), 8'h00};
         if (kind <= 4) begin
            a[7:0] = 8'(cl * 4);
            d[0] = ($urandom_range(0, 3) != 0);
            d[1] = ($urandom_range(0, 5) == 0);
         end else if (kind <= 6) begin
            a[7:0] = 8'(64 + cl * 4);
         end else if (kind == 7) begin
            a[7:0] = 8'h80;
         end else if (kind == 8) begin
            a[7:0] = 8'($urandom_range(0, 255));
         end else begin
            a[7:0] = 8'(cl * 4 + int'($urandom_range(1, 3)));
         end
         applyStimulus(a, d, s, wr, rd, er);
         gap = int'($urandom_range(0, 15));
         repeat (gap) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
